// File: rtl/l1_mem_scheduler.sv
// l1_mem_scheduler
// Shares the single downstream memory port between two L1 clients:
// L1a is client 0 and L1b is client 1.
//
// Each client has its own request FIFO. The two FIFOs are arbitrated
// round-robin. The block limits the number of reads in flight, routes
// tagged read returns back to the issuing client, and runs a
// flush/drain sequence before a coherence quiesce.
//
// Optional build macro WRITE_PRIORITY_EN:
//   When both heads are candidates and exactly one of them is a write,
//   the write wins. Otherwise arbitration is pure round-robin.
//
// Handshake: a request transfers on a posedge where req_valid_x and
// req_ready_x are both high. A read return transfers on a posedge where
// resp_valid_x and resp_ready_x are both high. Otherwise mem_en drops
// and the memory pipeline holds the return steady.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/ready/wr/addr/wdata _a/_b  client request channel
//   resp_data, resp_valid_a/_b, resp_ready_a/_b  read return channel
//   mem_addr, mem_wdata, mem_rden, mem_wren, mem_client_id  registered issue
//   mem_rdata, mem_rvalid, mem_rclient_id  memory return
//   mem_en  downstream pipeline enable
//   flush_req / flush_done  drain handshake
//   buffer_full  either FIFO full
//   fsm_state  debug view of the RUN/DRAIN/DONE state
module l1_mem_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 6,
  parameter int CNT_W           = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid_a,
  input  logic         req_valid_b,
  output logic         req_ready_a,
  output logic         req_ready_b,
  input  logic         req_wr_a,
  input  logic         req_wr_b,
  input  logic [31:0]  req_addr_a,
  input  logic [31:0]  req_addr_b,
  input  logic [127:0] req_wdata_a,
  input  logic [127:0] req_wdata_b,
  output logic [127:0] resp_data,
  output logic         resp_valid_a,
  output logic         resp_valid_b,
  input  logic         resp_ready_a,
  input  logic         resp_ready_b,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic         mem_rden,
  output logic         mem_wren,
  output logic         mem_client_id,
  input  logic [127:0] mem_rdata,
  input  logic         mem_rvalid,
  input  logic         mem_rclient_id,
  output logic         mem_en,
  input  logic         flush_req,
  output logic         flush_done,
  output logic         buffer_full,
  output logic [1:0]   fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_next;

  // Per-client FIFO storage, indexed [client][slot]
  logic [31:0]  addr_q [2][FIFO_DEPTH];
  logic [127:0] data_q [2][FIFO_DEPTH];
  logic         wr_q   [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr [2];
  logic [PTR_W-1:0] rptr [2];
  logic [PTR_W:0]   count [2];

  logic [1:0][31:0]  in_addr;
  logic [1:0][127:0] in_data;
  logic [1:0]        in_wr;
  logic [1:0] push, pop, empty, full, cand, head_wr, ready;

  logic [CNT_W-1:0] outstanding;
  logic cap_ok, any_grant, winner, issue, inc, dec, rr_ptr, drained;

  assign in_addr = {req_addr_b, req_addr_a};
  assign in_data = {req_wdata_b, req_wdata_a};
  assign in_wr   = {req_wr_b, req_wr_a};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      empty[c]   = (count[c] == '0);
      full[c]    = (count[c] == (PTR_W+1)'(FIFO_DEPTH));
      head_wr[c] = wr_q[c][rptr[c]];
      ready[c]   = ~full[c] & (state == RUN);
    end
  end

  assign req_ready_a = ready[0];
  assign req_ready_b = ready[1];
  assign push        = {req_valid_b & ready[1], req_valid_a & ready[0]};
  assign buffer_full = |full;

  // A return whose client is not ready freezes the whole memory pipeline
  assign mem_en       = ~(mem_rvalid & ~(mem_rclient_id ? resp_ready_b : resp_ready_a));
  assign resp_data    = mem_rdata;
  assign resp_valid_a = mem_rvalid & ~mem_rclient_id;
  assign resp_valid_b = mem_rvalid & mem_rclient_id;

  // Writes never count against the read cap
  assign cap_ok = (outstanding < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    for (int c = 0; c < 2; c++) cand[c] = ~empty[c] & (head_wr[c] | cap_ok);
    any_grant = |cand;
    winner    = cand[1];
    if (cand[0] & cand[1]) begin
`ifdef WRITE_PRIORITY_EN
      if (head_wr[0] != head_wr[1]) winner = head_wr[1];
      else                          winner = rr_ptr;
`else
      winner = rr_ptr;
`endif
    end
    issue = mem_en & any_grant;
    pop   = {issue & winner, issue & ~winner};
    inc   = issue & ~head_wr[winner];
    dec   = mem_rvalid & mem_en;
  end

  // FIFO storage (no reset needed, validity is tracked by count)
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        addr_q[c][wptr[c]] <= in_addr[c];
        data_q[c][wptr[c]] <= in_data[c];
        wr_q[c][wptr[c]]   <= in_wr[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        wptr[c]  <= '0;
        rptr[c]  <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + 1'b1;
        if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Issue registers, round-robin pointer and outstanding-read counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_rden      <= 1'b0;
      mem_wren      <= 1'b0;
      mem_client_id <= 1'b0;
      rr_ptr        <= 1'b0;
      outstanding   <= '0;
    end else begin
      if (mem_en) begin
        if (any_grant) begin
          mem_addr      <= addr_q[winner][rptr[winner]];
          mem_wdata     <= data_q[winner][rptr[winner]];
          mem_rden      <= ~head_wr[winner];
          mem_wren      <= head_wr[winner];
          mem_client_id <= winner;
          rr_ptr        <= ~winner;
        end else begin
          mem_rden <= 1'b0;
          mem_wren <= 1'b0;
        end
      end
      // Returns left over from before a reset must not underflow the count
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= (outstanding != '0) ? outstanding - 1'b1 : outstanding;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Flush FSM
  assign drained = (&empty) & (outstanding == '0) & ~mem_rden & ~mem_wren;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req)  state_next = DRAIN;
      DRAIN:   if (drained)    state_next = DONE;
      DONE:    if (!flush_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= (state_next == DONE);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_l1_mem_scheduler.sv
// Directed testbench for l1_mem_scheduler.
// Runs reset, single read, contention, outstanding cap, backpressure
// and FIFO-full/flush sequences. Expected values are hand-computed.
module tb_l1_mem_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_a, req_valid_b, req_ready_a, req_ready_b;
  logic         req_wr_a, req_wr_b;
  logic [31:0]  req_addr_a, req_addr_b;
  logic [127:0] req_wdata_a, req_wdata_b;
  logic [127:0] resp_data;
  logic         resp_valid_a, resp_valid_b, resp_ready_a, resp_ready_b;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_rden, mem_wren, mem_client_id;
  logic [127:0] mem_rdata;
  logic         mem_rvalid, mem_rclient_id, mem_en;
  logic         flush_req, flush_done, buffer_full;
  logic [1:0]   fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int pushed, rd_cnt;
  logic acc;

  l1_mem_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
    .req_wr_a(req_wr_a), .req_wr_b(req_wr_b),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
    .resp_data(resp_data),
    .resp_valid_a(resp_valid_a), .resp_valid_b(resp_valid_b),
    .resp_ready_a(resp_ready_a), .resp_ready_b(resp_ready_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_client_id(mem_client_id),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rclient_id(mem_rclient_id),
    .mem_en(mem_en), .flush_req(flush_req), .flush_done(flush_done),
    .buffer_full(buffer_full), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a single-edge enqueue on a client
  task automatic set_a(input logic v, input logic wr, input logic [31:0] addr, input logic [127:0] d);
    req_valid_a = v; req_wr_a = wr; req_addr_a = addr; req_wdata_a = d;
  endtask

  task automatic set_b(input logic v, input logic wr, input logic [31:0] addr, input logic [127:0] d);
    req_valid_b = v; req_wr_b = wr; req_addr_b = addr; req_wdata_b = d;
  endtask

  task automatic expect_issue(input string tag, input logic rd, input logic wr,
                              input logic id, input logic [31:0] addr);
    check({tag, "_rden"}, 128'(mem_rden), 128'(rd));
    check({tag, "_wren"}, 128'(mem_wren), 128'(wr));
    check({tag, "_id"},   128'(mem_client_id), 128'(id));
    check({tag, "_addr"}, 128'(mem_addr), 128'(addr));
  endtask

  initial begin
    reset = 1'b0;
    set_a(1'b1, 1'b0, 32'h40, '0);
    set_b(1'b0, 1'b0, '0, '0);
    resp_ready_a = 1'b1; resp_ready_b = 1'b1;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_rclient_id = 1'b0;
    flush_req = 1'b0;

    // ---- Reset with a request strobe held ----
    tick();
    tick();
    check("rst_rden",   128'(mem_rden), 128'(0));
    check("rst_wren",   128'(mem_wren), 128'(0));
    check("rst_addr",   128'(mem_addr), 128'(0));
    check("rst_wdata",  mem_wdata, '0);
    check("rst_id",     128'(mem_client_id), 128'(0));
    check("rst_fdone",  128'(flush_done), 128'(0));
    check("rst_bfull",  128'(buffer_full), 128'(0));
    check("rst_state",  128'(fsm_state), 128'(0));
    set_a(1'b0, 1'b0, 32'h40, '0);
    reset = 1'b1;
    check("rst_ready_a", 128'(req_ready_a), 128'(1));
    // Stale return after reset: counter must stay at zero
    mem_rvalid = 1'b1; mem_rclient_id = 1'b0;
    #1;
    check("stale_resp_a", 128'(resp_valid_a), 128'(1));
    tick();
    mem_rvalid = 1'b0;
    check("post_rst_rden", 128'(mem_rden), 128'(0));

    // ---- Single read from a ----
    set_a(1'b1, 1'b0, 32'h0000_0040, '0);
    tick();                                   // edge E: enqueue
    set_a(1'b0, 1'b0, '0, '0);
    check("rd_E_rden", 128'(mem_rden), 128'(0));
    tick();                                   // edge E+1: issue
    expect_issue("rd_E1", 1'b1, 1'b0, 1'b0, 32'h40);
    tick();
    check("rd_pulse", 128'(mem_rden), 128'(0));
    tick(); tick(); tick();
    mem_rvalid = 1'b1; mem_rclient_id = 1'b0;
    mem_rdata = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    #1;
    check("ret_valid_a", 128'(resp_valid_a), 128'(1));
    check("ret_valid_b", 128'(resp_valid_b), 128'(0));
    check("ret_data", resp_data, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("ret_once", 128'(resp_valid_a), 128'(0));

    // ---- Contention: pointer at a after reset ----
    do_reset();
    set_a(1'b1, 1'b0, 32'h100, '0);
    set_b(1'b1, 1'b0, 32'h200, '0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    expect_issue("cont1_first", 1'b1, 1'b0, 1'b0, 32'h100);
    tick();
    expect_issue("cont1_second", 1'b1, 1'b0, 1'b1, 32'h200);
    // Single a grant moves the pointer to b
    set_a(1'b1, 1'b0, 32'h300, '0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    tick();
    expect_issue("cont_single", 1'b1, 1'b0, 1'b0, 32'h300);
    set_a(1'b1, 1'b0, 32'h400, '0);
    set_b(1'b1, 1'b0, 32'h500, '0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    expect_issue("cont2_first", 1'b1, 1'b0, 1'b1, 32'h500);
    tick();
    expect_issue("cont2_second", 1'b1, 1'b0, 1'b0, 32'h400);

    // ---- b write vs a read, pointer at a ----
    do_reset();
    set_a(1'b1, 1'b0, 32'h600, '0);
    set_b(1'b1, 1'b1, 32'h700, 128'h1234);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();
`ifdef WRITE_PRIORITY_EN
    expect_issue("wp_first", 1'b0, 1'b1, 1'b1, 32'h700);
    check("wp_wdata", mem_wdata, 128'h1234);
    tick();
    expect_issue("wp_second", 1'b1, 1'b0, 1'b0, 32'h600);
`else
    expect_issue("wp_first", 1'b1, 1'b0, 1'b0, 32'h600);
    tick();
    expect_issue("wp_second", 1'b0, 1'b1, 1'b1, 32'h700);
    check("wp_wdata", mem_wdata, 128'h1234);
`endif

    // ---- Outstanding cap: 8 reads from a ----
    do_reset();
    pushed = 0;
    rd_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      set_a(pushed < 8, 1'b0, 32'h1000 + 32'(pushed) * 32'h40, '0);
      acc = req_valid_a & req_ready_a;
      tick();
      if (acc) pushed++;
      if (mem_rden) rd_cnt++;
    end
    set_a(1'b0, 1'b0, '0, '0);
    check("cap_pushed", 128'(pushed), 128'(8));
    check("cap_strobes", 128'(rd_cnt), 128'(6));
    check("cap_blocked", 128'(mem_rden), 128'(0));
    set_b(1'b1, 1'b1, 32'h2000, 128'hBEEF);
    tick();
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    expect_issue("cap_write", 1'b0, 1'b1, 1'b1, 32'h2000);
    check("cap_write_data", mem_wdata, 128'hBEEF);
    tick();
    check("cap_after_wr", 128'(mem_rden | mem_wren), 128'(0));
    mem_rvalid = 1'b1; mem_rclient_id = 1'b0;
    tick();                                   // return edge: no bypass
    mem_rvalid = 1'b0;
    check("cap_no_bypass", 128'(mem_rden), 128'(0));
    tick();
    expect_issue("cap_7th", 1'b1, 1'b0, 1'b0, 32'h1180);

    // ---- Backpressure on client b return ----
    do_reset();
    set_b(1'b1, 1'b0, 32'h3000, '0);
    tick();
    set_b(1'b0, 1'b0, '0, '0);
    set_a(1'b1, 1'b0, 32'h3100, '0);
    tick();
    expect_issue("bp_b_issue", 1'b1, 1'b0, 1'b1, 32'h3000);
    set_a(1'b0, 1'b0, '0, '0);
    tick();
    expect_issue("bp_a_issue", 1'b1, 1'b0, 1'b0, 32'h3100);
    mem_rvalid = 1'b1; mem_rclient_id = 1'b1; resp_ready_b = 1'b0;
    mem_rdata = 128'hCAFE_0000_0000_0000_0000_0000_0000_F00D;
    #1;
    check("bp_mem_en", 128'(mem_en), 128'(0));
    check("bp_valid_b", 128'(resp_valid_b), 128'(1));
    check("bp_valid_a", 128'(resp_valid_a), 128'(0));
    tick();
    tick();
    expect_issue("bp_hold", 1'b1, 1'b0, 1'b0, 32'h3100);
    check("bp_hold_valid", 128'(resp_valid_b), 128'(1));
    check("bp_hold_data", resp_data, 128'hCAFE_0000_0000_0000_0000_0000_0000_F00D);
    resp_ready_b = 1'b1;
    #1;
    check("bp_release_en", 128'(mem_en), 128'(1));
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("bp_after_rden", 128'(mem_rden), 128'(0));
    check("bp_after_valid", 128'(resp_valid_b), 128'(0));

    // ---- FIFO full under stall, then flush ----
    do_reset();
    mem_rvalid = 1'b1; mem_rclient_id = 1'b0; resp_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 1'b0, 32'h4000 + 32'(i) * 32'h40, '0);
      tick();
    end
    check("full_bfull", 128'(buffer_full), 128'(1));
    check("full_ready_a", 128'(req_ready_a), 128'(0));
    check("full_ready_b", 128'(req_ready_b), 128'(1));
    check("full_no_issue", 128'(mem_rden), 128'(0));
    set_a(1'b0, 1'b0, '0, '0);
    mem_rvalid = 1'b0; resp_ready_a = 1'b1; flush_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_issue($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b0, 32'h4000 + 32'(i) * 32'h40);
    end
    check("drain_state", 128'(fsm_state), 128'(1));
    check("drain_ready_a", 128'(req_ready_a), 128'(0));
    check("drain_ready_b", 128'(req_ready_b), 128'(0));
    tick();
    check("drain_idle", 128'(mem_rden), 128'(0));
    check("drain_not_done", 128'(flush_done), 128'(0));
    mem_rvalid = 1'b1; mem_rclient_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain_ret%0d_done", i), 128'(flush_done), 128'(0));
    end
    mem_rvalid = 1'b0;
    tick();
    check("flush_done", 128'(flush_done), 128'(1));
    check("done_state", 128'(fsm_state), 128'(2));
    check("done_ready_a", 128'(req_ready_a), 128'(0));
    tick();
    check("flush_done_hold", 128'(flush_done), 128'(1));
    flush_req = 1'b0;
    tick();
    check("flush_clear", 128'(flush_done), 128'(0));
    check("run_ready_a", 128'(req_ready_a), 128'(1));
    check("run_state", 128'(fsm_state), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
